// File: rtl/aes_pkg.sv
// Shared types and constants for the masked AES S-box sharing logic.
package aes_pkg;

   localparam int unsigned SBOX_LATENCY_DEFAULT = 5;

   typedef enum logic {
      OWNER_ST  = 1'b0,
      OWNER_KEY = 1'b1
   } sbox_owner_e;

   typedef enum logic [1:0] {
      ARB_IDLE     = 2'd0,
      ARB_LOCK_ST  = 2'd1,
      ARB_LOCK_KEY = 2'd2,
      ARB_FLUSH    = 2'd3
   } sbox_arb_state_e;

endpackage

// File: rtl/aes_sbox_tag_pipe.sv
// Valid/owner tag shift register that tracks bytes in flight through a fixed-latency shared unit.
module aes_sbox_tag_pipe
   import aes_pkg::*;
#(
   parameter int unsigned Depth = SBOX_LATENCY_DEFAULT
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        flush,
   input  logic        push_valid,
   input  sbox_owner_e push_owner,
   output logic        tail_valid,
   output sbox_owner_e tail_owner,
   output logic        any_valid
);

   logic [Depth-1:0] valid_q;
   sbox_owner_e      owner_q [Depth];

   // Flush drops every tag at once; owners are don't-care while invalid.
   always_ff @(posedge clk) begin
      if (rst) begin
         valid_q <= '0;
         for (int i = 0; i < int'(Depth); i++) begin
            owner_q[i] <= OWNER_ST;
         end
      end else if (flush) begin
         valid_q <= '0;
      end else begin
         valid_q[0] <= push_valid;
         owner_q[0] <= push_owner;
         for (int i = 1; i < int'(Depth); i++) begin
            valid_q[i] <= valid_q[i-1];
            owner_q[i] <= owner_q[i-1];
         end
      end
   end

   assign tail_valid = valid_q[Depth-1];
   assign tail_owner = owner_q[Depth-1];
   assign any_valid  = |valid_q;

endmodule

// File: rtl/aes_sbox_share_arb.sv
// Arbitrates state/key byte bursts onto one shared masked S-box and routes results to their owner.
// Optional AES_SBOX_ARB_RR_EN selects round-robin in IDLE; default is fixed key-over-state priority.
module aes_sbox_share_arb
   import aes_pkg::*;
#(
   parameter int unsigned DataWidth   = 16,
   parameter int unsigned SBoxLatency = SBOX_LATENCY_DEFAULT
) (
   input  logic                 clk_i,
   input  logic                 rst_i,
   input  logic                 st_req_i,
   input  logic                 st_last_i,
   input  logic [DataWidth-1:0] st_data_i,
   output logic                 st_gnt_o,
   input  logic                 key_req_i,
   input  logic                 key_last_i,
   input  logic [DataWidth-1:0] key_data_i,
   output logic                 key_gnt_o,
   output logic                 sbox_valid_o,
   output logic [DataWidth-1:0] sbox_data_o,
   input  logic                 sbox_valid_i,
   input  logic [DataWidth-1:0] sbox_data_i,
   output logic                 st_rsp_valid_o,
   output logic                 key_rsp_valid_o,
   output logic [DataWidth-1:0] rsp_data_o,
   output logic                 prng_update_o,
   input  logic                 clear_i,
   output logic                 busy_o,
   output logic                 err_o
);

   localparam int unsigned CntW = $clog2(SBoxLatency + 1);

   sbox_arb_state_e state_q;
   logic [CntW-1:0] flush_cnt_q;
   sbox_owner_e     issue_owner_q;
   logic            st_acc;
   logic            key_acc;
   logic            flushing;
   logic            tag_valid;
   logic            tag_any;
   sbox_owner_e     tag_owner;
   logic            tag_mismatch;

`ifdef AES_SBOX_ARB_RR_EN
   sbox_owner_e last_win_q;
`endif

   // Grants are combinational so a requester can stream one byte per cycle.
   always_comb begin
      st_gnt_o  = 1'b0;
      key_gnt_o = 1'b0;
      if (!rst_i && !clear_i) begin
         case (state_q)
            ARB_IDLE: begin
`ifdef AES_SBOX_ARB_RR_EN
               if (st_req_i && key_req_i) begin
                  st_gnt_o  = (last_win_q == OWNER_KEY);
                  key_gnt_o = (last_win_q == OWNER_ST);
               end else begin
                  st_gnt_o  = st_req_i;
                  key_gnt_o = key_req_i;
               end
`else
               key_gnt_o = key_req_i;
               st_gnt_o  = st_req_i & ~key_req_i;
`endif
            end
            ARB_LOCK_ST:  st_gnt_o  = st_req_i;
            ARB_LOCK_KEY: key_gnt_o = key_req_i;
            default: begin
               st_gnt_o  = 1'b0;
               key_gnt_o = 1'b0;
            end
         endcase
      end
   end

   assign st_acc   = st_req_i & st_gnt_o;
   assign key_acc  = key_req_i & key_gnt_o;
   assign flushing = clear_i | (state_q == ARB_FLUSH);

   // Results landing during a flush are stale and neither routed nor checked.
   assign tag_mismatch    = ~flushing & (sbox_valid_i != tag_valid);
   assign st_rsp_valid_o  = ~rst_i & ~flushing & sbox_valid_i & tag_valid & (tag_owner == OWNER_ST);
   assign key_rsp_valid_o = ~rst_i & ~flushing & sbox_valid_i & tag_valid & (tag_owner == OWNER_KEY);
   assign rsp_data_o      = sbox_data_i;
   assign busy_o          = (state_q != ARB_IDLE) | tag_any | sbox_valid_o;

   aes_sbox_tag_pipe #(
      .Depth (SBoxLatency)
   ) u_tag_pipe (
      .clk        (clk_i),
      .rst        (rst_i),
      .flush      (clear_i),
      .push_valid (sbox_valid_o),
      .push_owner (issue_owner_q),
      .tail_valid (tag_valid),
      .tail_owner (tag_owner),
      .any_valid  (tag_any)
   );

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q       <= ARB_IDLE;
         flush_cnt_q   <= '0;
         issue_owner_q <= OWNER_ST;
         sbox_valid_o  <= 1'b0;
         sbox_data_o   <= '0;
         prng_update_o <= 1'b0;
         err_o         <= 1'b0;
`ifdef AES_SBOX_ARB_RR_EN
         last_win_q    <= OWNER_KEY;
`endif
      end else begin
         sbox_valid_o  <= st_acc | key_acc;
         prng_update_o <= st_acc | key_acc;
         if (key_acc) begin
            sbox_data_o   <= key_data_i;
            issue_owner_q <= OWNER_KEY;
         end else if (st_acc) begin
            sbox_data_o   <= st_data_i;
            issue_owner_q <= OWNER_ST;
         end
         if (tag_mismatch) begin
            err_o <= 1'b1;
         end
`ifdef AES_SBOX_ARB_RR_EN
         if (key_acc && key_last_i) begin
            last_win_q <= OWNER_KEY;
         end else if (st_acc && st_last_i) begin
            last_win_q <= OWNER_ST;
         end
`endif
         if (clear_i) begin
            state_q     <= ARB_FLUSH;
            flush_cnt_q <= CntW'(SBoxLatency);
         end else begin
            case (state_q)
               ARB_IDLE: begin
                  if (key_acc && !key_last_i) begin
                     state_q <= ARB_LOCK_KEY;
                  end else if (st_acc && !st_last_i) begin
                     state_q <= ARB_LOCK_ST;
                  end
               end
               ARB_LOCK_ST: begin
                  if (st_acc && st_last_i) begin
                     state_q <= ARB_IDLE;
                  end
               end
               ARB_LOCK_KEY: begin
                  if (key_acc && key_last_i) begin
                     state_q <= ARB_IDLE;
                  end
               end
               default: begin
                  if (flush_cnt_q == '0) begin
                     state_q <= ARB_IDLE;
                  end else begin
                     flush_cnt_q <= flush_cnt_q - CntW'(1);
                  end
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_aes_sbox_share_arb.sv
// Self-checking bench for aes_sbox_share_arb with a fixed-latency XOR S-box model.
module tb_aes_sbox_share_arb;
   import aes_pkg::*;

   localparam int unsigned L  = 5;
   localparam int unsigned DW = 16;
   localparam logic [DW-1:0] SBOX_XOR = 16'h5A3C;

   logic clk = 1'b0;
   logic rst_i, clear_i;
   logic st_req_i, st_last_i, key_req_i, key_last_i;
   logic [DW-1:0] st_data_i, key_data_i;
   logic st_gnt_o, key_gnt_o, sbox_valid_o, sbox_valid_i;
   logic [DW-1:0] sbox_data_o, sbox_data_i, rsp_data_o;
   logic st_rsp_valid_o, key_rsp_valid_o, prng_update_o, busy_o, err_o;

   logic inject;
   logic [L-1:0] mv;
   logic [DW-1:0] md [L];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   aes_sbox_share_arb #(.DataWidth(DW), .SBoxLatency(L)) dut (
      .clk_i(clk), .rst_i(rst_i),
      .st_req_i(st_req_i), .st_last_i(st_last_i), .st_data_i(st_data_i), .st_gnt_o(st_gnt_o),
      .key_req_i(key_req_i), .key_last_i(key_last_i), .key_data_i(key_data_i), .key_gnt_o(key_gnt_o),
      .sbox_valid_o(sbox_valid_o), .sbox_data_o(sbox_data_o),
      .sbox_valid_i(sbox_valid_i), .sbox_data_i(sbox_data_i),
      .st_rsp_valid_o(st_rsp_valid_o), .key_rsp_valid_o(key_rsp_valid_o), .rsp_data_o(rsp_data_o),
      .prng_update_o(prng_update_o), .clear_i(clear_i), .busy_o(busy_o), .err_o(err_o)
   );

   // Shared S-box model: fixed L-cycle pipeline, result = input ^ SBOX_XOR.
   always @(posedge clk) begin
      if (rst_i) begin
         mv <= '0;
      end else begin
         mv <= {mv[L-2:0], sbox_valid_o};
         md[0] <= sbox_data_o ^ SBOX_XOR;
         for (int i = 1; i < int'(L); i++) md[i] <= md[i-1];
      end
   end
   assign sbox_valid_i = mv[L-1] | inject;
   assign sbox_data_i  = inject ? 16'hBEEF : md[L-1];

   typedef struct {
      logic st_req, st_last, key_req, key_last;
      logic [DW-1:0] st_data, key_data;
      logic exp_st_gnt, exp_key_gnt, exp_issue;
      logic [DW-1:0] exp_sbox_data;
   } vec_t;
   vec_t vecs[10];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      st_req_i = 0; st_last_i = 0; key_req_i = 0; key_last_i = 0; clear_i = 0; inject = 0;
   endtask

   task automatic wait_idle();
      for (int n = 0; n < 40; n++) begin
         next_cycle();
         #1;
         if (!busy_o) break;
      end
      chk("wait_idle_busy", busy_o, 0);
   endtask

   task automatic chk_all_zero(input string tag);
      chk({tag, "_st_gnt"}, st_gnt_o, 0);
      chk({tag, "_key_gnt"}, key_gnt_o, 0);
      chk({tag, "_sbox_valid"}, sbox_valid_o, 0);
      chk({tag, "_sbox_data"}, sbox_data_o, 0);
      chk({tag, "_prng"}, prng_update_o, 0);
      chk({tag, "_st_rsp"}, st_rsp_valid_o, 0);
      chk({tag, "_key_rsp"}, key_rsp_valid_o, 0);
      chk({tag, "_busy"}, busy_o, 0);
      chk({tag, "_err"}, err_o, 0);
   endtask

   initial begin
      logic [DW-1:0] prev_data;
      logic prev_acc;

      // Table: four tie cycles, a 3-byte state burst with key waiting, then a key byte.
      prev_acc = 0; prev_data = '0;
      for (int i = 0; i < 10; i++) begin
         vecs[i].st_data  = 16'h0100 + DW'(i);
         vecs[i].key_data = 16'h0200 + DW'(i);
         vecs[i].st_req = 0; vecs[i].st_last = 0; vecs[i].key_req = 0; vecs[i].key_last = 0;
         vecs[i].exp_st_gnt = 0; vecs[i].exp_key_gnt = 0;
         if (i < 4) begin
            vecs[i].st_req = 1; vecs[i].st_last = 1; vecs[i].key_req = 1; vecs[i].key_last = 1;
`ifdef AES_SBOX_ARB_RR_EN
            vecs[i].exp_st_gnt = (i % 2 == 0);
`else
            vecs[i].exp_st_gnt = 0;
`endif
            vecs[i].exp_key_gnt = !vecs[i].exp_st_gnt;
         end else if (i == 4) begin
            vecs[i].st_req = 1; vecs[i].exp_st_gnt = 1;
         end else if (i == 5 || i == 6) begin
            vecs[i].st_req = 1; vecs[i].st_last = (i == 6);
            vecs[i].key_req = 1; vecs[i].key_last = 1;
            vecs[i].exp_st_gnt = 1;
         end else if (i == 7) begin
            vecs[i].key_req = 1; vecs[i].key_last = 1; vecs[i].exp_key_gnt = 1;
         end
         vecs[i].exp_issue = prev_acc;
         vecs[i].exp_sbox_data = prev_data;
         prev_acc = vecs[i].exp_st_gnt | vecs[i].exp_key_gnt;
         if (vecs[i].exp_key_gnt) prev_data = vecs[i].key_data;
         else if (vecs[i].exp_st_gnt) prev_data = vecs[i].st_data;
      end

      idle_inputs();
      st_data_i = '0; key_data_i = '0;
      rst_i = 1;
      repeat (2) next_cycle();
      #1;
      chk_all_zero("reset");
      rst_i = 0;

      // Single key byte: grant at T, issue at T+1, response at T+1+L.
      next_cycle();
      key_req_i = 1; key_last_i = 1; key_data_i = 16'h1234;
      #1;
      chk("single_key_gnt", key_gnt_o, 1);
      chk("single_st_gnt", st_gnt_o, 0);
      next_cycle();
      idle_inputs();
      #1;
      chk("single_sbox_valid", sbox_valid_o, 1);
      chk("single_prng", prng_update_o, 1);
      chk("single_sbox_data", sbox_data_o, 16'h1234);
      for (int k = 2; k <= 5; k++) begin
         next_cycle(); #1;
         chk($sformatf("single_early_rsp_t%0d", k), key_rsp_valid_o, 0);
      end
      next_cycle(); #1;
      chk("single_key_rsp", key_rsp_valid_o, 1);
      chk("single_st_rsp", st_rsp_valid_o, 0);
      chk("single_rsp_data", rsp_data_o, 16'h4808);
      next_cycle(); #1;
      chk("single_one_pulse", sbox_valid_o, 0);
      wait_idle();

      for (int i = 0; i < 10; i++) begin
         next_cycle();
         st_req_i = vecs[i].st_req; st_last_i = vecs[i].st_last; st_data_i = vecs[i].st_data;
         key_req_i = vecs[i].key_req; key_last_i = vecs[i].key_last; key_data_i = vecs[i].key_data;
         #1;
         chk($sformatf("vec%0d_st_gnt", i), st_gnt_o, vecs[i].exp_st_gnt);
         chk($sformatf("vec%0d_key_gnt", i), key_gnt_o, vecs[i].exp_key_gnt);
         chk($sformatf("vec%0d_issue", i), sbox_valid_o, vecs[i].exp_issue);
         chk($sformatf("vec%0d_prng", i), prng_update_o, vecs[i].exp_issue);
         if (vecs[i].exp_issue)
            chk($sformatf("vec%0d_sbox_data", i), sbox_data_o, vecs[i].exp_sbox_data);
      end
      idle_inputs();
      wait_idle();
      chk("vec_err", err_o, 0);

      // 16-byte state burst holds off key requests arriving from byte 3.
      for (int i = 0; i < 16; i++) begin
         next_cycle();
         st_req_i = 1; st_last_i = (i == 15); st_data_i = 16'h0300 + DW'(i);
         key_req_i = (i >= 2); key_last_i = 1; key_data_i = 16'h0400;
         #1;
         chk($sformatf("lock_st_gnt%0d", i), st_gnt_o, 1);
         chk($sformatf("lock_key_gnt%0d", i), key_gnt_o, 0);
      end
      next_cycle();
      st_req_i = 0; st_last_i = 0;
      #1;
      chk("lock_key_after", key_gnt_o, 1);
      next_cycle();
      idle_inputs();
      wait_idle();
      chk("lock_err", err_o, 0);

      // Clear with three bytes in flight, and a request in the clear cycle.
      for (int i = 0; i < 3; i++) begin
         next_cycle();
         st_req_i = 1; st_last_i = 1; st_data_i = 16'h0500 + DW'(i);
         #1;
         chk($sformatf("clr_pre_gnt%0d", i), st_gnt_o, 1);
      end
      next_cycle();
      clear_i = 1;
      #1;
      chk("clr_no_gnt", st_gnt_o, 0);
      chk("clr_last_issue", sbox_valid_o, 1);
      next_cycle();
      idle_inputs();
      #1;
      chk("clr_no_issue", sbox_valid_o, 0);
      for (int k = 0; k < 6; k++) begin
         chk($sformatf("clr_busy%0d", k), busy_o, 1);
         chk($sformatf("clr_st_rsp%0d", k), st_rsp_valid_o, 0);
         chk($sformatf("clr_key_rsp%0d", k), key_rsp_valid_o, 0);
         next_cycle(); #1;
      end
      chk("clr_busy_end", busy_o, 0);
      chk("clr_err", err_o, 0);
      st_req_i = 1; st_last_i = 1; st_data_i = 16'h0555;
      #1;
      chk("clr_new_gnt", st_gnt_o, 1);
      next_cycle();
      idle_inputs();
      repeat (4) next_cycle();
      next_cycle(); #1;
      chk("clr_new_rsp", st_rsp_valid_o, 1);
      chk("clr_new_rsp_data", rsp_data_o, 16'h5F69);
      wait_idle();

      // Stray S-box valid with no tag in flight.
      next_cycle();
      inject = 1;
      #1;
      chk("fault_st_rsp", st_rsp_valid_o, 0);
      chk("fault_key_rsp", key_rsp_valid_o, 0);
      chk("fault_err_same", err_o, 0);
      next_cycle();
      inject = 0;
      #1;
      chk("fault_err_set", err_o, 1);
      repeat (3) next_cycle();
      #1;
      chk("fault_err_sticky", err_o, 1);
      next_cycle();
      rst_i = 1;
      next_cycle();
      rst_i = 0;
      #1;
      chk("fault_err_reset", err_o, 0);

      // Reset in the middle of a locked key burst.
      next_cycle();
      key_req_i = 1; key_last_i = 0; key_data_i = 16'h0777;
      #1;
      chk("rst_key_gnt0", key_gnt_o, 1);
      next_cycle();
      st_req_i = 1; st_last_i = 1; st_data_i = 16'h0888;
      #1;
      chk("rst_key_gnt1", key_gnt_o, 1);
      chk("rst_st_blocked", st_gnt_o, 0);
      next_cycle();
      rst_i = 1;
      next_cycle(); #1;
      chk_all_zero("rst_lock");
      next_cycle();
      rst_i = 0; key_req_i = 0; key_last_i = 0;
      #1;
      chk("rst_st_gnt_after", st_gnt_o, 1);
      next_cycle();
      idle_inputs();
      wait_idle();
      chk("final_err", err_o, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
